clk_div_bank: RTL and testbench

- Multi-channel, runtime-programmable square-wave clock divider. It generalises the fixed 100 MHz to 1 MHz divider.
- Each channel produces a 50%-duty divided output and a one-cycle rising-edge tick. The piano tone, beat and scan logic consume these.
- Half-period divisors are written through a valid/ready config port.
- A new divisor on a running channel takes effect only at a half-period boundary, so no runt pulses are produced.

---
 rtl/clk_div_bank_pkg.sv | 11 +
 rtl/clk_div_bank_if.sv | 13 +
 rtl/clk_div_channel.sv | 59 +++++
 rtl/clk_div_bank.sv | 35 +++
 tb/tb_clk_div_bank.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/clk_div_bank_pkg.sv
// clk_div_bank_pkg: shared divider widths, default and standard half-period divisors, channel-select width helper
package clk_div_bank_pkg;
    localparam int DEF_CNT_W         = 16;
    localparam int DEFAULT_HALF_1MHZ = 50;
    localparam int HALF_100KHZ       = 500;
    localparam int HALF_10KHZ        = 5000;
    localparam int HALF_1KHZ         = 50000;
    function automatic int ch_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: divisor config port; master drives cfg_valid/cfg_ch/cfg_half, slave returns cfg_ready
interface clk_div_bank_if import clk_div_bank_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int CH_W   = ch_width(NUM_CH)
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one 50%-duty divider with shadowed half-period.
// Ports: clk, rst_n (async low); en run enable; load/load_val accepted divisor write;
// direct_load applies the write at once (channel disabled); clk_out, tick (rise pulse), pending.
module clk_div_channel import clk_div_bank_pkg::*; #(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEFAULT_HALF_1MHZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             direct_load,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    logic [CNT_W-1:0] cnt, half_active, shadow;
    logic parked, wrap;
    assign parked = half_active == '0;
    assign wrap   = cnt >= half_active - CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            half_active <= CNT_W'(DEFAULT_HALF);
            shadow      <= CNT_W'(DEFAULT_HALF);
            pending     <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
        end else if (load && (direct_load || parked)) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            half_active <= load_val;
            pending     <= 1'b0;
        end else if (!en || parked) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (pending) begin
                half_active <= shadow;
                pending     <= 1'b0;
            end
        end else begin
            cnt     <= wrap ? '0 : cnt + CNT_W'(1);
            clk_out <= clk_out ^ wrap;
            tick    <= wrap && !clk_out;
            // the shadow only lands on a half-period boundary so no runt pulse appears
            if (wrap && pending) begin
                half_active <= shadow;
                pending     <= 1'b0;
            end
            if (load) begin
                shadow  <= load_val;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable square-wave dividers.
// Ports: clk, rst_n (async low); ch_en per-channel enable; cfg config port (slave);
// clk_out divided clocks; tick one-cycle rise pulses; pending shadow divisor waiting per channel.
module clk_div_bank import clk_div_bank_pkg::*; #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEFAULT_HALF_1MHZ,
    parameter int CH_W         = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    logic xfer;
    // writes to channels that do not exist are accepted and dropped
    assign cfg.cfg_ready = int'(cfg.cfg_ch) >= NUM_CH || !pending[cfg.cfg_ch];
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (ch_en[i]),
            .load        (xfer && cfg.cfg_ch == CH_W'(i)),
            .load_val    (cfg.cfg_half),
            .direct_load (!ch_en[i]),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .pending     (pending[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: expected tick cycles are queued per channel when stimulus is driven and
// popped by a monitor whenever a tick appears; directed checks cover levels, pending and ready.
module tb_clk_div_bank;
    import clk_div_bank_pkg::*;
    localparam int NCH = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] clk_out, tick, pending;
    int cyc = 0, n_chk = 0, n_fail = 0, base = 0;
    int exp_q[NCH][$];
    clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(DEF_CNT_W)) cfg ();
    clk_div_bank #(.NUM_CH(NCH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_en   (ch_en),
        .cfg     (cfg),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask
    task automatic push(input int c, input int first, input int step, input int last);
        for (int t = first; t <= last; t += step) exp_q[c].push_back(base + t);
    endtask
    task automatic drive(input logic v, input int ch, input int half);
        cfg.cfg_valid = v;
        cfg.cfg_ch    = 2'(ch);
        cfg.cfg_half  = DEF_CNT_W'(half);
    endtask
    always @(negedge clk) begin : mon
        int want;
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (tick[c]) begin
                    want = -1;
                    if (exp_q[c].size() != 0) want = exp_q[c].pop_front();
                    check($sformatf("ch%0d tick cycle", c), cyc, want);
                    check($sformatf("ch%0d clk_out at tick", c), int'(clk_out[c]), 1);
                end
            end
        end
    end
    initial begin
        drive(1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset clk_out", clk_out, 0);
        check("reset tick", tick, 0);
        check("reset pending", pending, 0);
        check("reset ready", cfg.cfg_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        base  = cyc;
        ch_en = '1;
        push(0, 50, 100, 200);
        push(1, 50, 1, 50);
        push(1, 70, 20, 200);
        push(2, 50, 1, 50);
        push(2, 75, 10, 200);
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            case (t)
                20: drive(1'b1, 1, 10);
                21: begin
                    check("ch1 pending set", pending[1], 1);
                    check("ch1 ready low", cfg.cfg_ready, 0);
                    drive(1'b0, 1, 10);
                end
                30: drive(1'b1, 2, 20);
                31: begin
                    check("ch2 pending set", pending[2], 1);
                    drive(1'b1, 2, 5);
                end
                40: check("ch2 stall ready", cfg.cfg_ready, 0);
                49: check("ch0 low before rise", clk_out[0], 0);
                50: begin
                    check("ch0 first rise", clk_out[0], 1);
                    check("ch1 pending cleared", pending[1], 0);
                    check("ch2 ready after wrap", cfg.cfg_ready, 1);
                end
                51: begin
                    check("ch2 held transfer", pending[2], 1);
                    drive(1'b0, 2, 5);
                end
                70: check("ch2 pending cleared", pending[2], 0);
                99: check("ch0 high half", clk_out[0], 1);
                100: check("ch0 fall", clk_out[0], 0);
                default: ;
            endcase
        end
        ch_en = '0;
        repeat (5) @(negedge clk);
        base  = cyc;
        ch_en = 3'b011;
        push(0, 50, 1, 50);
        push(0, 95, 8, 116);
        push(1, 10, 20, 116);
        push(2, 61, 2, 116);
        for (int t = 1; t <= 116; t++) begin
            @(negedge clk);
            case (t)
                10: drive(1'b1, 0, 0);
                11: begin
                    check("ch0 zero pending", pending[0], 1);
                    drive(1'b0, 0, 0);
                end
                20: drive(1'b1, 2, 1);
                21: begin
                    check("ch2 direct no pending", pending[2], 0);
                    drive(1'b0, 2, 1);
                end
                50: begin
                    check("ch0 toggle before park", clk_out[0], 1);
                    check("ch0 pending applied", pending[0], 0);
                end
                51: check("ch0 forced low", clk_out[0], 0);
                60: ch_en[2] = 1'b1;
                61: check("ch2 half1 rise", clk_out[2], 1);
                62: check("ch2 half1 fall", clk_out[2], 0);
                80: check("ch0 parked", clk_out[0], 0);
                90: drive(1'b1, 0, 4);
                91: begin
                    check("ch0 unpark no pending", pending[0], 0);
                    drive(1'b0, 0, 4);
                end
                94: check("ch0 unpark low", clk_out[0], 0);
                95: check("ch0 unpark rise", clk_out[0], 1);
                112: drive(1'b1, 1, 30);
                113: begin
                    check("ch1 pending before reset", pending[1], 1);
                    drive(1'b0, 1, 30);
                end
                116: begin
                    check("pre-reset pending", pending, 3'b010);
                    check("pre-reset clk_out", clk_out, 3'b010);
                end
                default: ;
            endcase
        end
        #2 rst_n = 1'b0;
        #1;
        check("async reset clk_out", clk_out, 0);
        check("async reset tick", tick, 0);
        check("async reset pending", pending, 0);
        ch_en = '0;
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        ch_en = '1;
        for (int c = 0; c < NCH; c++) push(c, 50, 1, 50);
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            case (t)
                5: begin
                    drive(1'b1, 3, 7);
                    check("bad ch ready", cfg.cfg_ready, 1);
                end
                6: begin
                    check("bad ch dropped", pending, 0);
                    drive(1'b0, 0, 7);
                end
                49: check("post-reset low", clk_out, 0);
                50: check("post-reset default rise", clk_out, 3'b111);
                default: ;
            endcase
        end
        for (int c = 0; c < NCH; c++) check($sformatf("ch%0d ticks missing", c), exp_q[c].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
